// File: rtl/kc705_ethernet_rgmii_axi_rx_frame_filter.sv
// Byte-wide AXI-Stream RX filter: buffers the Ethernet header, then replays and forwards
// frames for this board (unicast or broadcast) with the configured EtherType; drops the rest.
module kc705_ethernet_rgmii_axi_rx_frame_filter #(
    parameter int HDR_BYTES = 14,
    parameter int CNT_W     = 16
) (
    input  logic             axi_tclk,
    input  logic             axi_tresetn,
    input  logic             enable_filter,
    input  logic [47:0]      local_mac,
    input  logic [15:0]      match_ethertype,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    input  logic             rx_axis_tuser,
    output logic             rx_axis_tready,
    output logic [7:0]       tdata,
    output logic             tvalid,
    output logic             tlast,
    output logic             tuser,
    input  logic             tready,
    output logic [CNT_W-1:0] frame_pass_count,
    output logic [CNT_W-1:0] frame_drop_count
);

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        REPLAY = 2'd1,
        FWD    = 2'd2,
        DROP   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(HDR_BYTES - 1);

    state_t             r_state;
    logic [3:0]         r_idx;
    logic [3:0]         r_ridx;
    logic [7:0]         r_hdr [HDR_BYTES];
    logic               r_en_l;
    logic [47:0]        r_mac_l;
    logic [15:0]        r_type_l;
    logic               r_last13;
    logic               r_user13;
    logic               r_rdy_en;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_hdr_acc;
    logic [47:0]        w_dst;
    logic               w_dst_match;
    logic               w_type_match;
    logic               w_pass;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Pass/drop decision; byte 13 comes straight from the input bus
    always_comb begin
        w_hdr_acc    = (r_state == HDR) && r_rdy_en && rx_axis_tvalid;
        w_dst        = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], r_hdr[5]};
        w_dst_match  = (w_dst == r_mac_l) || (w_dst == 48'hFFFF_FFFF_FFFF);
        w_type_match = ({r_hdr[12], rx_axis_tdata} == r_type_l);
        w_pass       = !r_en_l || (w_dst_match && w_type_match);
    end

    // Output steering per state; FWD is a zero-latency pass-through
    always_comb begin
        rx_axis_tready = 1'b0;
        tdata          = 8'h00;
        tvalid         = 1'b0;
        tlast          = 1'b0;
        tuser          = 1'b0;
        case (r_state)
            HDR: begin
                rx_axis_tready = r_rdy_en;
            end
            REPLAY: begin
                tvalid = 1'b1;
                tdata  = r_hdr[r_ridx];
                tlast  = (r_ridx == LAST_IDX) ? r_last13 : 1'b0;
                tuser  = (r_ridx == LAST_IDX) ? r_user13 : 1'b0;
            end
            FWD: begin
                rx_axis_tready = tready;
                tdata          = rx_axis_tdata;
                tvalid         = rx_axis_tvalid;
                tlast          = rx_axis_tlast;
                tuser          = rx_axis_tuser;
            end
            DROP: begin
                rx_axis_tready = r_rdy_en;
            end
            default: begin
                rx_axis_tready = 1'b0;
            end
        endcase
    end

    // Frame state machine, header capture and saturating counters
    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) begin
            r_state    <= HDR;
            r_idx      <= 4'd0;
            r_ridx     <= 4'd0;
            for (int i = 0; i < HDR_BYTES; i++) begin
                r_hdr[i] <= 8'h00;
            end
            r_en_l     <= 1'b0;
            r_mac_l    <= 48'h0;
            r_type_l   <= 16'h0;
            r_last13   <= 1'b0;
            r_user13   <= 1'b0;
            r_rdy_en   <= 1'b0;
            r_pass_cnt <= {CNT_W{1'b0}};
            r_drop_cnt <= {CNT_W{1'b0}};
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                HDR: begin
                    if (w_hdr_acc) begin
                        r_hdr[r_idx] <= rx_axis_tdata;
                        if (r_idx == 4'd0) begin
                            r_en_l   <= enable_filter;
                            r_mac_l  <= local_mac;
                            r_type_l <= match_ethertype;
                        end else begin
                            r_en_l   <= r_en_l;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_idx    <= 4'd0;
                            r_last13 <= rx_axis_tlast;
                            r_user13 <= rx_axis_tuser;
                            if (w_pass) begin
                                r_state    <= REPLAY;
                                r_ridx     <= 4'd0;
                                r_pass_cnt <= sat_inc(r_pass_cnt);
                            end else begin
                                r_state    <= rx_axis_tlast ? HDR : DROP;
                                r_drop_cnt <= sat_inc(r_drop_cnt);
                            end
                        end else if (rx_axis_tlast) begin
                            // Runt: discard silently and start over
                            r_idx      <= 4'd0;
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                REPLAY: begin
                    if (tready) begin
                        if (r_ridx == LAST_IDX) begin
                            r_ridx  <= 4'd0;
                            r_state <= r_last13 ? HDR : FWD;
                        end else begin
                            r_ridx <= r_ridx + 4'd1;
                        end
                    end else begin
                        r_ridx <= r_ridx;
                    end
                end
                FWD: begin
                    if (rx_axis_tvalid && tready && rx_axis_tlast) begin
                        r_state <= HDR;
                    end else begin
                        r_state <= FWD;
                    end
                end
                DROP: begin
                    if (rx_axis_tvalid && rx_axis_tlast) begin
                        r_state <= HDR;
                    end else begin
                        r_state <= DROP;
                    end
                end
                default: begin
                    r_state <= HDR;
                    r_idx   <= 4'd0;
                end
            endcase
        end
    end

    assign frame_pass_count = r_pass_cnt;
    assign frame_drop_count = r_drop_cnt;

endmodule
